// File: rtl/dqs_write_sequencer_if.sv
// Write-burst request and shifter-control bundle between the memory-controller
// side (master) and the DQS write sequencer (slave).
`timescale 1ns/1ps
interface dqs_write_sequencer_if;
  logic       i_req;
  logic       o_ready;
  logic       i_bl16;
  logic [2:0] i_gap;
  logic [2:0] i_pre_len;
  logic       i_post_len;
  logic       o_preamble_load;
  logic       o_preamble_valid;
  logic       o_wr_en;
  logic       o_interamble_valid;
  logic [2:0] o_interamble_shift;
  logic       o_dqs_oe;
  logic [2:0] o_state;
  logic       o_busy;

  modport master (
    output i_req, i_bl16, i_gap, i_pre_len, i_post_len,
    input  o_ready, o_preamble_load, o_preamble_valid, o_wr_en,
           o_interamble_valid, o_interamble_shift, o_dqs_oe, o_state, o_busy
  );

  modport slave (
    input  i_req, i_bl16, i_gap, i_pre_len, i_post_len,
    output o_ready, o_preamble_load, o_preamble_valid, o_wr_en,
           o_interamble_valid, o_interamble_shift, o_dqs_oe, o_state, o_busy
  );
endinterface

// File: rtl/dqs_write_sequencer.sv
// DQS write sequencer: buffers one write-burst request and walks each burst
// through LOAD -> preamble -> data -> interamble/postamble, driving the DQS
// preamble/interamble shifter controls, write-data enable and DQS output enable.
`timescale 1ns/1ps
module dqs_write_sequencer #(
  parameter int PRE_MAX = 4,
  parameter int GAP_MAX = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  dqs_write_sequencer_if.slave      bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PRE   = 3'd2,
    ST_DATA  = 3'd3,
    ST_INTER = 3'd4,
    ST_POST  = 3'd5
  } state_t;

  localparam logic [2:0] LP_PRE_MAX = 3'(PRE_MAX);
  localparam logic [3:0] LP_GAP_MAX = 4'(GAP_MAX);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic [3:0] w_cnt_inc;
  logic       w_consume;
  logic       w_accept;

  logic       r_pend_valid;
  logic       r_pend_bl16;
  logic [2:0] r_pend_gap;

  logic       r_bl16;
  logic [2:0] r_gap;
  logic [2:0] r_pre_len;
  logic       r_post_len;
  logic [2:0] w_pre_clamped;
  logic [3:0] w_data_len;
  logic [3:0] w_post_cycles;

  // The slot only accepts while empty, so accept and consume never coincide.
  assign w_accept      = bus.i_req & ~r_pend_valid;
  assign w_cnt_inc     = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
  assign w_data_len    = r_bl16 ? 4'd8 : 4'd4;
  assign w_post_cycles = r_post_len ? 4'd2 : 4'd1;

  // Clamp the requested preamble length into 1..PRE_MAX.
  always_comb begin
    w_pre_clamped = bus.i_pre_len;
    if (bus.i_pre_len == 3'd0)
      w_pre_clamped = 3'd1;
    else if (bus.i_pre_len > LP_PRE_MAX)
      w_pre_clamped = LP_PRE_MAX;
  end

  // Next-state, phase counter and slot-consume decisions.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = w_cnt_inc;
    w_consume    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = 4'd0;
        if (r_pend_valid) begin
          w_state_next = ST_LOAD;
          w_consume    = 1'b1;
        end
      end
      ST_LOAD: begin
        w_state_next = ST_PRE;
        w_cnt_next   = 4'd1;
      end
      ST_PRE: begin
        if (r_cnt >= {1'b0, r_pre_len}) begin
          w_state_next = ST_DATA;
          w_cnt_next   = 4'd1;
        end
      end
      ST_DATA: begin
        if (r_cnt >= w_data_len) begin
          w_cnt_next = 4'd1;
          if (r_pend_valid && r_pend_gap == 3'd0) begin
            w_state_next = ST_DATA;
            w_consume    = 1'b1;
          end else if (r_pend_valid && {1'b0, r_pend_gap} <= LP_GAP_MAX) begin
            w_state_next = ST_INTER;
            w_consume    = 1'b1;
          end else begin
            w_state_next = ST_POST;
          end
        end
      end
      ST_INTER: begin
        if (r_cnt >= {1'b0, r_gap}) begin
          w_state_next = ST_DATA;
          w_cnt_next   = 4'd1;
        end
      end
      ST_POST: begin
        if (r_cnt >= w_post_cycles) begin
          w_cnt_next = 4'd0;
          if (r_pend_valid) begin
            w_state_next = ST_LOAD;
            w_consume    = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // State register and phase counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // One-entry request slot holding {bl16, gap}.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend_valid <= 1'b0;
      r_pend_bl16  <= 1'b0;
      r_pend_gap   <= 3'd0;
    end else if (w_consume) begin
      r_pend_valid <= 1'b0;
    end else if (w_accept) begin
      r_pend_valid <= 1'b1;
      r_pend_bl16  <= bus.i_bl16;
      r_pend_gap   <= bus.i_gap;
    end
  end

  // Burst config: bl16/gap taken from the slot when consumed, pre/post lengths in LOAD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bl16     <= 1'b0;
      r_gap      <= 3'd0;
      r_pre_len  <= 3'd0;
      r_post_len <= 1'b0;
    end else begin
      if (w_consume) begin
        r_bl16 <= r_pend_bl16;
        r_gap  <= r_pend_gap;
      end
      if (r_state == ST_LOAD) begin
        r_pre_len  <= w_pre_clamped;
        r_post_len <= bus.i_post_len;
      end
    end
  end

  // Moore output decode of the state register.
  always_comb begin
    bus.o_preamble_load    = 1'b0;
    bus.o_preamble_valid   = 1'b0;
    bus.o_wr_en            = 1'b0;
    bus.o_interamble_valid = 1'b0;
    bus.o_interamble_shift = 3'd0;
    bus.o_dqs_oe           = 1'b0;
    case (r_state)
      ST_LOAD:  bus.o_preamble_load = 1'b1;
      ST_PRE: begin
        bus.o_preamble_valid = 1'b1;
        bus.o_dqs_oe         = 1'b1;
      end
      ST_DATA: begin
        bus.o_wr_en  = 1'b1;
        bus.o_dqs_oe = 1'b1;
      end
      ST_INTER: begin
        bus.o_interamble_valid = 1'b1;
        bus.o_interamble_shift = r_cnt[2:0];
        bus.o_dqs_oe           = 1'b1;
      end
      ST_POST:  bus.o_dqs_oe = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_ready = ~r_pend_valid;
  assign bus.o_state = r_state;
  assign bus.o_busy  = (r_state != ST_IDLE) | r_pend_valid;

endmodule

// File: tb/tb_dqs_write_sequencer.sv
// Bench for dqs_write_sequencer: a burst-schedule model predicts every output
// each cycle, and directed scenarios pin specific cycle-level expectations.
`timescale 1ns/1ps
module tb_dqs_write_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dqs_write_sequencer_if bus();

  dqs_write_sequencer #(.PRE_MAX(4), .GAP_MAX(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- schedule model ----------------
  // The model keeps a plan of upcoming cycles (state code, interamble index,
  // decision marker). At decision points it appends the next burst segment.
  localparam int D_NONE = 0, D_IDLE = 1, D_LOAD = 2, D_DLAST = 3, D_PLAST = 4;
  typedef struct {
    logic [2:0] st;
    logic [2:0] sh;
    int         dec;
  } ent_t;

  ent_t plan[$];
  ent_t cur;
  bit   m_pend;
  bit   m_pbl16;
  int   m_pgap;
  bit   m_bl16;
  int   m_pre;
  int   m_post;

  function automatic ent_t mk(logic [2:0] st, logic [2:0] sh, int dec);
    ent_t e;
    e.st = st; e.sh = sh; e.dec = dec;
    return e;
  endfunction

  function automatic int clamp_pre(int p);
    return (p == 0) ? 1 : ((p > 4) ? 4 : p);
  endfunction

  task automatic push_data();
    int n;
    n = m_bl16 ? 8 : 4;
    for (int i = 0; i < n; i++)
      plan.push_back(mk(3'd3, 3'd0, (i == n - 1) ? D_DLAST : D_NONE));
  endtask

  task automatic take_slot();
    m_bl16 = m_pbl16;
    m_pend = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      plan.delete();
      cur    = mk(3'd0, 3'd0, D_IDLE);
      m_pend = 1'b0;
      m_bl16 = 1'b0;
      m_pre  = 1;
      m_post = 1;
    end else begin
      bit acc;
      int g;
      acc = bus.i_req && !m_pend;
      case (cur.dec)
        D_IDLE, D_PLAST: begin
          if (m_pend) begin
            take_slot();
            plan.push_back(mk(3'd1, 3'd0, D_LOAD));
          end else begin
            plan.push_back(mk(3'd0, 3'd0, D_IDLE));
          end
        end
        D_LOAD: begin
          m_pre  = clamp_pre(int'(bus.i_pre_len));
          m_post = bus.i_post_len ? 2 : 1;
          for (int i = 0; i < m_pre; i++) plan.push_back(mk(3'd2, 3'd0, D_NONE));
          push_data();
        end
        D_DLAST: begin
          if (m_pend && m_pgap == 0) begin
            take_slot();
            push_data();
          end else if (m_pend && m_pgap <= 6) begin
            g = m_pgap;
            take_slot();
            for (int i = 1; i <= g; i++) plan.push_back(mk(3'd4, 3'(i), D_NONE));
            push_data();
          end else begin
            for (int i = 0; i < m_post; i++)
              plan.push_back(mk(3'd5, 3'd0, (i == m_post - 1) ? D_PLAST : D_NONE));
          end
        end
        default: ;
      endcase
      cur = plan.pop_front();
      if (acc) begin
        m_pend  = 1'b1;
        m_pbl16 = bus.i_bl16;
        m_pgap  = int'(bus.i_gap);
      end
    end
  end

  function automatic logic [12:0] exp_vec(ent_t e, bit pend);
    logic       iv;
    logic [2:0] sh;
    logic       oe;
    iv = (e.st == 3'd4);
    sh = iv ? e.sh : 3'd0;
    oe = (e.st == 3'd2) || (e.st == 3'd3) || (e.st == 3'd4) || (e.st == 3'd5);
    return {~pend, e.st == 3'd1, e.st == 3'd2, e.st == 3'd3, iv, sh, oe, e.st,
            (e.st != 3'd0) || pend};
  endfunction

  logic [12:0] dut_v;
  assign dut_v = {bus.o_ready, bus.o_preamble_load, bus.o_preamble_valid, bus.o_wr_en,
                  bus.o_interamble_valid, bus.o_interamble_shift, bus.o_dqs_oe,
                  bus.o_state, bus.o_busy};

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      logic [12:0] ev;
      ev = exp_vec(cur, m_pend);
      n_vec++;
      if (dut_v !== ev) begin
        n_err++;
        $display("FAIL cycle t=%0t outputs {rdy,ld,pv,wr,iv,sh,oe,st,busy} dut=%b model=%b",
                 $time, dut_v, ev);
      end
    end
  end

  // ---------------- activity monitor for literal checks ----------------
  int wr_run = 0, last_wr_run = 0, wr_total = 0;
  int pre_run = 0;
  int pre_runs[$];
  int load_cnt = 0, post_cnt = 0, inter_cnt = 0;
  int shifts[$];
  int oe_low = 0, last_oe_low = 0, oe_run = 0, last_oe_run = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_wr_en) begin wr_run++; wr_total++; end
      else if (wr_run != 0) begin last_wr_run = wr_run; wr_run = 0; end
      if (bus.o_preamble_valid) pre_run++;
      else if (pre_run != 0) begin pre_runs.push_back(pre_run); pre_run = 0; end
      if (bus.o_preamble_load) load_cnt++;
      if (bus.o_state == 3'd5) post_cnt++;
      if (bus.o_interamble_valid) begin inter_cnt++; shifts.push_back(int'(bus.o_interamble_shift)); end
      if (bus.o_dqs_oe) begin
        if (oe_low != 0) last_oe_low = oe_low;
        oe_low = 0;
        oe_run++;
      end else begin
        oe_low++;
        if (oe_run != 0) begin last_oe_run = oe_run; oe_run = 0; end
      end
    end
  end

  task automatic mon_clr();
    wr_run = 0; last_wr_run = 0; wr_total = 0; pre_run = 0; pre_runs.delete();
    load_cnt = 0; post_cnt = 0; inter_cnt = 0; shifts.delete();
    oe_low = 0; last_oe_low = 0; oe_run = 0; last_oe_run = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(bit bl16, logic [2:0] gap);
    int k;
    k = 0;
    while (!bus.o_ready && k < 100) begin step(); k++; end
    if (k >= 100) chk("send_ready_timeout", 0, 1);
    bus.i_req  = 1'b1;
    bus.i_bl16 = bl16;
    bus.i_gap  = gap;
    step();
    bus.i_req  = 1'b0;
    bus.i_bl16 = ~bl16;
    bus.i_gap  = ~gap;
  endtask

  task automatic wait_wr();
    int k;
    k = 0;
    while (!bus.o_wr_en && k < 100) begin step(); k++; end
    if (k >= 100) chk("wait_wr_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.o_busy && k < 200) begin step(); k++; end
    if (k >= 200) chk("wait_idle_timeout", 0, 1);
    step(2);
  endtask

  initial begin
    bus.i_req      = 1'b0;
    bus.i_bl16     = 1'b0;
    bus.i_gap      = 3'd0;
    bus.i_pre_len  = 3'd2;
    bus.i_post_len = 1'b0;
    step(3);
    chk("reset_ready", int'(bus.o_ready), 1);
    chk("reset_state", int'(bus.o_state), 0);
    rst = 1'b0;
    step(2);

    // 1: single BL8, pre 2, post 1 cycle; cycle n follows edge n-1
    mon_clr();
    send(1'b0, 3'd5);
    chk("t1_c1_ready", int'(bus.o_ready), 0);
    step();
    chk("t1_c2_load", int'(bus.o_preamble_load), 1);
    chk("t1_c2_oe", int'(bus.o_dqs_oe), 0);
    step();
    chk("t1_c3_pv", int'(bus.o_preamble_valid), 1);
    chk("t1_c3_oe", int'(bus.o_dqs_oe), 1);
    bus.i_pre_len = 3'd4;
    step();
    chk("t1_c4_pv", int'(bus.o_preamble_valid), 1);
    step();
    chk("t1_c5_wr", int'(bus.o_wr_en), 1);
    chk("t1_c5_pv", int'(bus.o_preamble_valid), 0);
    step(3);
    chk("t1_c8_wr", int'(bus.o_wr_en), 1);
    step();
    chk("t1_c9_state", int'(bus.o_state), 5);
    chk("t1_c9_oe", int'(bus.o_dqs_oe), 1);
    step();
    chk("t1_c10_state", int'(bus.o_state), 0);
    chk("t1_c10_oe", int'(bus.o_dqs_oe), 0);
    wait_idle();

    // 2: BL16 then seamless BL16 (gap 0) accepted during first DATA
    bus.i_pre_len = 3'd1;
    mon_clr();
    send(1'b1, 3'd5);
    wait_wr();
    send(1'b1, 3'd0);
    wait_idle();
    chk("t2_wr_run", last_wr_run, 16);
    chk("t2_pre_runs", pre_runs.size(), 1);
    chk("t2_post", post_cnt, 1);

    // 3: BL8, then BL8 after a 3-cycle interamble
    mon_clr();
    send(1'b0, 3'd0);
    wait_wr();
    send(1'b0, 3'd3);
    wait_idle();
    chk("t3_inter_cnt", inter_cnt, 3);
    chk("t3_shift0", (shifts.size() > 0) ? shifts[0] : -1, 1);
    chk("t3_shift1", (shifts.size() > 1) ? shifts[1] : -1, 2);
    chk("t3_shift2", (shifts.size() > 2) ? shifts[2] : -1, 3);
    chk("t3_oe_run", last_oe_run, 13);
    chk("t3_load", load_cnt, 1);

    // 4: gap 7 forces postamble (2 cycles) and a fresh LOAD/preamble
    bus.i_post_len = 1'b1;
    mon_clr();
    send(1'b0, 3'd0);
    wait_wr();
    send(1'b0, 3'd7);
    wait_idle();
    chk("t4_load", load_cnt, 2);
    chk("t4_post", post_cnt, 4);
    chk("t4_oe_low", last_oe_low, 1);
    chk("t4_oe_run", last_oe_run, 7);

    // 5: pre_len 0 clamps to 1, pre_len 6 clamps to 4; request while full is dropped
    bus.i_pre_len  = 3'd0;
    bus.i_post_len = 1'b0;
    mon_clr();
    send(1'b0, 3'd0);
    step(2);
    bus.i_pre_len = 3'd6;
    wait_wr();
    send(1'b0, 3'd7);
    chk("t5_ready_pending", int'(bus.o_ready), 0);
    bus.i_req  = 1'b1;
    bus.i_bl16 = 1'b1;
    bus.i_gap  = 3'd0;
    step();
    bus.i_req = 1'b0;
    wait_idle();
    chk("t5_pre_runs", pre_runs.size(), 2);
    chk("t5_pre0", (pre_runs.size() > 0) ? pre_runs[0] : -1, 1);
    chk("t5_pre1", (pre_runs.size() > 1) ? pre_runs[1] : -1, 4);
    chk("t5_load", load_cnt, 2);
    chk("t5_wr_total", wr_total, 8);

    // 6: asynchronous reset in the second DATA cycle
    bus.i_pre_len = 3'd1;
    mon_clr();
    send(1'b0, 3'd0);
    wait_wr();
    step();
    chk("t6_wr_before", int'(bus.o_wr_en), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_outputs", int'(dut_v), 'h1000);
    step(2);
    rst = 1'b0;
    step(5);
    chk("t6_state_after", int'(bus.o_state), 0);
    chk("t6_busy_after", int'(bus.o_busy), 0);
    chk("t6_ready_after", int'(bus.o_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
